// File: rtl/food_spawner_pkg.sv
// Shared playfield geometry, coordinate types and spawner FSM encoding.
// SCAN state exists only when FOOD_SCAN_FALLBACK_EN is defined.
package snake_pkg;

    localparam int GRID_W_DEF    = 16;
    localparam int GRID_H_DEF    = 20;
    localparam int MAX_TRIES_DEF = 8;
    localparam int X_W           = 4;
    localparam int Y_W           = 5;

    typedef logic [X_W-1:0] coord_x_t;
    typedef logic [Y_W-1:0] coord_y_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRAW   = 3'd1,
        S_SAMPLE = 3'd2,
        S_QUERY  = 3'd3,
`ifdef FOOD_SCAN_FALLBACK_EN
        S_SCAN   = 3'd4,
`endif
        S_DONE   = 3'd5
    } spawn_state_t;

endpackage

// File: rtl/food_spawner_if.sv
// Spawner side-bus: LFSR advance/candidate and snake-body occupancy query.
// master = food_spawner, slave = random + body store.
interface food_spawner_if;
    import snake_pkg::*;

    logic     rng_update;
    coord_x_t rng4;
    coord_y_t rng5;
    logic     query_valid;
    coord_x_t query_x;
    coord_y_t query_y;
    logic     query_ack;
    logic     query_hit;

    modport master (
        output rng_update, query_valid, query_x, query_y,
        input  rng4, rng5, query_ack, query_hit
    );

    modport slave (
        input  rng_update, query_valid, query_x, query_y,
        output rng4, rng5, query_ack, query_hit
    );

endinterface

// File: rtl/food_spawner.sv
// Purpose: draws LFSR cells, rejects out-of-range/occupied ones, publishes food position.
// Latency: spawn_req -> spawn_done in 4 cycles + query ack latency (best case).
// Backpressure: query held until query_ack; spawn_req ignored while busy. Option: FOOD_SCAN_FALLBACK_EN.
module food_spawner
    import snake_pkg::*;
#(
    parameter int GRID_W    = GRID_W_DEF,
    parameter int GRID_H    = GRID_H_DEF,
    parameter int MAX_TRIES = MAX_TRIES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spawn_req,
    food_spawner_if.master        rq,
    output logic                  busy,
    output logic                  food_valid,
    output coord_x_t              food_x,
    output coord_y_t              food_y,
    output logic                  spawn_done,
    output logic                  spawn_fail
);

    // Limits widened by one bit so GRID_W=16 / GRID_H=32 compare without truncation.
    localparam logic [X_W:0] W_LIM = (X_W+1)'(GRID_W);
    localparam logic [Y_W:0] H_LIM = (Y_W+1)'(GRID_H);
    localparam logic [7:0]   T_LIM = 8'(MAX_TRIES);

    spawn_state_t state, state_nxt;
    logic [7:0]   tries;
    coord_x_t     qx;
    coord_y_t     qy;
    logic         out_rng, exhausted, fail_now, retry_fail;
    spawn_state_t retry_state;

`ifdef FOOD_SCAN_FALLBACK_EN
    localparam logic [X_W:0] W_MAX     = (X_W+1)'(GRID_W-1);
    localparam logic [Y_W:0] H_MAX     = (Y_W+1)'(GRID_H-1);
    localparam logic [9:0]   SCAN_LAST = 10'(GRID_W*GRID_H-1);
    logic [9:0]   scan_cnt;
    logic         have_cand;
`endif

    assign out_rng   = ({1'b0, rq.rng4} >= W_LIM) || ({1'b0, rq.rng5} >= H_LIM);
    assign exhausted = (tries >= T_LIM);

    always_comb begin
        retry_state = S_DRAW;
        retry_fail  = 1'b0;
        if (exhausted) begin
`ifdef FOOD_SCAN_FALLBACK_EN
            retry_state = S_SCAN;
`else
            retry_state = S_IDLE;
            retry_fail  = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fail_now  = 1'b0;
        case (state)
            S_IDLE:   if (spawn_req) state_nxt = S_DRAW;
            S_DRAW:   state_nxt = S_SAMPLE;
            S_SAMPLE: begin
                if (out_rng) begin
                    state_nxt = retry_state;
                    fail_now  = retry_fail;
                end else begin
                    state_nxt = S_QUERY;
                end
            end
            S_QUERY: begin
                if (rq.query_ack) begin
                    if (rq.query_hit) begin
                        state_nxt = retry_state;
                        fail_now  = retry_fail;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
`ifdef FOOD_SCAN_FALLBACK_EN
            S_SCAN: begin
                if (rq.query_ack) begin
                    if (!rq.query_hit) begin
                        state_nxt = S_DONE;
                    end else if (scan_cnt == SCAN_LAST) begin
                        state_nxt = S_IDLE;
                        fail_now  = 1'b1;
                    end
                end
            end
`endif
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rq.rng_update  = (state == S_DRAW);
`ifdef FOOD_SCAN_FALLBACK_EN
        rq.query_valid = (state == S_QUERY) || (state == S_SCAN);
`else
        rq.query_valid = (state == S_QUERY);
`endif
        rq.query_x     = qx;
        rq.query_y     = qy;
        busy           = (state != S_IDLE);
        spawn_done     = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tries      <= '0;
            qx         <= '0;
            qy         <= '0;
            food_valid <= 1'b0;
            food_x     <= '0;
            food_y     <= '0;
            spawn_fail <= 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
            scan_cnt   <= '0;
            have_cand  <= 1'b0;
`endif
        end else begin
            spawn_fail <= fail_now;
            case (state)
                S_IDLE: if (spawn_req) begin
                    tries      <= '0;
                    food_valid <= 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
                    have_cand  <= 1'b0;
`endif
                end
                S_DRAW:   tries <= tries + 8'd1;
                S_SAMPLE: if (!out_rng) begin
                    qx <= rq.rng4;
                    qy <= rq.rng5;
`ifdef FOOD_SCAN_FALLBACK_EN
                    have_cand <= 1'b1;
`endif
                end
                S_QUERY: if (rq.query_ack && !rq.query_hit) begin
                    food_x <= qx;
                    food_y <= qy;
                end
`ifdef FOOD_SCAN_FALLBACK_EN
                // Query stays asserted; each ack with hit moves to the next raster cell.
                S_SCAN: if (rq.query_ack) begin
                    if (!rq.query_hit) begin
                        food_x <= qx;
                        food_y <= qy;
                    end else begin
                        scan_cnt <= scan_cnt + 10'd1;
                        if ({1'b0, qx} == W_MAX) begin
                            qx <= '0;
                            qy <= ({1'b0, qy} == H_MAX) ? '0 : qy + 1'b1;
                        end else begin
                            qx <= qx + 1'b1;
                        end
                    end
                end
`endif
                S_DONE:   food_valid <= 1'b1;
                default:  ;
            endcase
`ifdef FOOD_SCAN_FALLBACK_EN
            if (state != S_SCAN && state_nxt == S_SCAN) begin
                scan_cnt <= '0;
                if (!have_cand) begin
                    qx <= '0;
                    qy <= '0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_food_spawner.sv
// Directed bench for food_spawner: LFSR table model, occupancy responder, per-test checks.
// Scan-fallback scenario replaces the give-up scenario when FOOD_SCAN_FALLBACK_EN is defined.
module tb_food_spawner;
    import snake_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    logic     spawn_req = 1'b0;
    logic     busy, food_valid, spawn_done, spawn_fail;
    coord_x_t food_x;
    coord_y_t food_y;

    food_spawner_if fif();

    food_spawner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spawn_req  (spawn_req),
        .rq         (fif),
        .busy       (busy),
        .food_valid (food_valid),
        .food_x     (food_x),
        .food_y     (food_y),
        .spawn_done (spawn_done),
        .spawn_fail (spawn_fail)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // LFSR stand-in: each rng_update presents the next table entry.
    logic [3:0] tbl_x [16];
    logic [4:0] tbl_y [16];
    int         idx = 0;
    int         upd_cnt = 0;
    // Responder: mode 0 = all free, 1 = all occupied, 2 = only (0,0) free.
    int         occ_mode = 0;
    bit         resp_en = 1'b1;
    bit         force_ack = 1'b0;
    int         wait_cnt = 0;
    int         nq = 0;
    int         q1x = -1, q1y = -1;

    function automatic logic occupied(input int mode, input logic [3:0] x, input logic [4:0] y);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return !(x == 4'd0 && y == 5'd0);
    endfunction

    initial begin
        fif.rng4 = '0;
        fif.rng5 = '0;
        fif.query_ack = 1'b0;
        fif.query_hit = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (fif.rng_update) begin
                fif.rng4 = tbl_x[idx];
                fif.rng5 = tbl_y[idx];
                idx++;
                upd_cnt++;
            end
            if (fif.query_ack) begin
                fif.query_ack = 1'b0;
                fif.query_hit = 1'b0;
                wait_cnt = 0;
            end else if (force_ack) begin
                fif.query_ack = 1'b1;
                fif.query_hit = 1'b0;
            end else if (resp_en && fif.query_valid) begin
                if (wait_cnt >= 1) begin
                    fif.query_ack = 1'b1;
                    fif.query_hit = occupied(occ_mode, fif.query_x, fif.query_y);
                    if (nq == 0) begin
                        q1x = int'(fif.query_x);
                        q1y = int'(fif.query_y);
                    end
                    nq++;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    bit got_done, got_fail, fv_at1;
    int lat;

    task automatic clear_counts();
        idx = 0; upd_cnt = 0; nq = 0; q1x = -1; q1y = -1;
    endtask

    // Raise spawn_req (one cycle, or held until completion) and wait for done/fail.
    task automatic run_spawn(input bit hold, input int budget, input string tag);
        got_done = 1'b0; got_fail = 1'b0; lat = 0; fv_at1 = 1'b1;
        @(negedge clk);
        spawn_req = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (c == 1) begin
                fv_at1 = food_valid;
                if (!hold) spawn_req = 1'b0;
            end
            if (spawn_done) begin got_done = 1'b1; lat = c; break; end
            if (spawn_fail) begin got_fail = 1'b1; lat = c; break; end
        end
        spawn_req = 1'b0;
        if (!got_done && !got_fail) chk({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        // Reset state
        #23;
        chk("rst_busy", busy, 0);
        chk("rst_food_valid", food_valid, 0);
        chk("rst_rng_update", fif.rng_update, 0);
        chk("rst_query_valid", fif.query_valid, 0);
        chk("rst_done_fail", {spawn_done, spawn_fail}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single in-range free draw
        clear_counts(); occ_mode = 0;
        tbl_x[0] = 4'd5; tbl_y[0] = 5'd7;
        run_spawn(1'b0, 40, "t2");
        chk("t2_done", got_done, 1);
        chk("t2_latency", lat, 5);
        chk("t2_upd", upd_cnt, 1);
        chk("t2_nq", nq, 1);
        chk("t2_qxy", {q1x[7:0], q1y[7:0]}, {8'd5, 8'd7});
        chk("t2_food", {food_x, food_y}, {4'd5, 5'd7});
        @(negedge clk);
        chk("t2_fvalid", food_valid, 1);
        chk("t2_done_pulse", spawn_done, 0);
        chk("t2_busy", busy, 0);

        // Out-of-range y rejected without a query
        clear_counts();
        tbl_x[0] = 4'd3; tbl_y[0] = 5'd25;
        tbl_x[1] = 4'd3; tbl_y[1] = 5'd2;
        run_spawn(1'b0, 40, "t3");
        chk("t3_fv_cleared", fv_at1, 0);
        chk("t3_done", got_done, 1);
        chk("t3_upd", upd_cnt, 2);
        chk("t3_nq", nq, 1);
        chk("t3_food", {food_x, food_y}, {4'd3, 5'd2});

        // spawn_req held through a spawn: one spawn only
        clear_counts();
        tbl_x[0] = 4'd9; tbl_y[0] = 5'd19;
        tbl_x[1] = 4'd1; tbl_y[1] = 5'd1;
        run_spawn(1'b1, 40, "t5");
        repeat (6) @(negedge clk);
        chk("t5_upd", upd_cnt, 1);
        chk("t5_idle", busy, 0);
        chk("t5_food", {food_x, food_y}, {4'd9, 5'd19});

        // All random cells occupied
        clear_counts();
        for (int i = 0; i < 8; i++) begin
            tbl_x[i] = 4'(i + 1);
            tbl_y[i] = 5'(i + 1);
        end
`ifdef FOOD_SCAN_FALLBACK_EN
        occ_mode = 2;
        run_spawn(1'b0, 3000, "t4s");
        chk("t4s_done", got_done, 1);
        chk("t4s_upd", upd_cnt, 8);
        chk("t4s_nq", nq, 193);
        chk("t4s_food", {food_x, food_y}, {4'd0, 5'd0});
`else
        occ_mode = 1;
        run_spawn(1'b0, 200, "t4");
        chk("t4_fail", got_fail, 1);
        chk("t4_upd", upd_cnt, 8);
        chk("t4_nq", nq, 8);
        chk("t4_fvalid", food_valid, 0);
        chk("t4_busy", busy, 0);
`endif
        occ_mode = 0;

        // Reset mid-QUERY, late ack ignored, then a normal spawn
        clear_counts(); resp_en = 1'b0;
        tbl_x[0] = 4'd4; tbl_y[0] = 5'd4;
        @(negedge clk);
        spawn_req = 1'b1;
        @(negedge clk);
        spawn_req = 1'b0;
        for (int c = 0; c < 10 && !fif.query_valid; c++) @(negedge clk);
        chk("t6_in_query", fif.query_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_qvalid", fif.query_valid, 0);
        chk("t6_food", {food_valid, food_x, food_y}, 0);
        chk("t6_pulses", {fif.rng_update, spawn_done, spawn_fail}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_late_ack_busy", busy, 0);
        chk("t6_late_ack_fv", {food_valid, spawn_done}, 0);
        clear_counts(); resp_en = 1'b1;
        tbl_x[0] = 4'd6; tbl_y[0] = 5'd9;
        run_spawn(1'b0, 40, "t6b");
        chk("t6b_done", got_done, 1);
        chk("t6b_food", {food_x, food_y}, {4'd6, 5'd9});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/food_spawner.md
Name: food_spawner

Overview:
Places a new food item on the snake playfield. On request it draws random coordinates from the LFSR block (random), rejects out-of-range draws and cells occupied by the snake (via a query handshake to the snake body store), then publishes the accepted food position. It sits directly downstream of random, drives its update input, and feeds the game-logic/render stages.

Parameters:
GRID_W, 16, playfield width in cells (1..16; x coordinate 4 bits)
GRID_H, 20, playfield height in cells (1..32; y coordinate 5 bits)
MAX_TRIES, 8, random draws attempted before giving up (1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous assert, active-low
spawn_req  in  1  one-cycle pulse: place new food (sampled only when busy=0)
rng_update  out  1  advance pulse to random.update
rng4  in  4  random x candidate (random.rng4)
rng5  in  5  random y candidate (random.rng5)
query_valid  out  1  occupancy query pending
query_x  out  4  queried cell x
query_y  out  5  queried cell y
query_ack  in  1  query answered this cycle
query_hit  in  1  cell occupied (valid only with query_ack)
busy  out  1  spawn in progress
food_valid  out  1  food_x/food_y hold a placed food
food_x  out  4  food x
food_y  out  5  food y
spawn_done  out  1  one-cycle pulse: food placed
spawn_fail  out  1  one-cycle pulse: no cell found

Behaviour:
- Reset (any time, incl. mid-spawn): state IDLE; all outputs 0; try counter 0. Outstanding query is abandoned; a late query_ack is ignored in IDLE.
- FSM states: IDLE, DRAW, SAMPLE, QUERY, (SCAN with feature), DONE.
- IDLE: busy=0. spawn_req=1 -> DRAW; food_valid cleared same edge; tries=0.
- DRAW: rng_update=1 for exactly one cycle; tries++ ; -> SAMPLE.
- SAMPLE: rng4/rng5 now hold the advanced value. If rng4>=GRID_W or rng5>=GRID_H: reject -> retry rule. Else register query_x=rng4, query_y=rng5, -> QUERY.
- QUERY: query_valid=1, query_x/y stable until query_ack. ack with hit=0 -> food_x/y<=query_x/y, -> DONE. ack with hit=1 -> retry rule. query_valid drops the cycle after ack.
- Retry rule: tries<MAX_TRIES -> DRAW; else (feature off) spawn_fail pulse, -> IDLE with food_valid=0.
- DONE: food_valid<=1, spawn_done=1 one cycle, -> IDLE.
- busy=1 in every state except IDLE; spawn_req while busy ignored.
- Best-case latency spawn_req -> spawn_done: 4 cycles + query ack latency.
- Comparisons unsigned at full 4/5-bit width; no truncation.
- food_valid/food_x/food_y hold until next accepted spawn_req or reset.

Optional Feature:
FOOD_SCAN_FALLBACK_EN. Defined: on try exhaustion, enter SCAN starting at last in-range candidate (or (0,0) if none), query cells raster-order (x++, wrap to 0 and y++, wrap y at GRID_H to 0); first hit=0 -> DONE; after GRID_W*GRID_H queries all hit -> spawn_fail. Guarantees placement whenever a free cell exists, including cells the LFSR never yields (x=0, y=0). Undefined: exhaustion -> spawn_fail immediately, no SCAN state or scan counter.

Decomposition:
snake_pkg: GRID_W/GRID_H defaults, X_W=4, Y_W=5, typedefs coord_x_t/coord_y_t, spawn_state_t enum. No sub-module; FSM, try counter and scan counter in one module.

Test Plan:
- Reset low mid-QUERY -> all outputs 0, busy=0; late query_ack=1 ignored; next spawn_req works.
- spawn_req; rng4=5,rng5=7; ack with hit=0 after 1 cycle -> exactly one rng_update pulse, query (5,7), food=(5,7), food_valid=1, spawn_done 1 cycle.
- rng5=25 (>=20) then rng4=3,rng5=2 free -> first draw rejected without query, two rng_update pulses, food=(3,2).
- Every query hit=1, MAX_TRIES=8, feature off -> 8 rng_update pulses, 8 queries, spawn_fail pulse, food_valid=0.
- Feature on, all random cells hit, only (0,0) free -> scan wraps, food=(0,0), spawn_done.
- spawn_req held high during spawn -> only one spawn occurs; second spawn_req after IDLE starts new one.
